ifu_fetch: RTL and testbench
============================

// Module: ifu_fetch
// PURPOSE
//   Instruction fetch unit, upstream of the single-cycle core.
//   Takes the core's current pc and reads the instruction word from instruction memory
//   over a valid/ready read channel. Presents the word as cmd, holds it stable and flags it
//   valid until the core acknowledges commit.
//   The core's PC write-enable is driven from cmd_valid & cmd_ack, so one instruction
//   retires per completed fetch.
// PARAMETERS
//   ADDR_W     32            instruction address width
//   DATA_W     32            instruction word width
//   TIMEOUT    255           max cycles from AR entry to rvalid before error (>=1)
//   RESET_CMD  32'h00000013  word driven on cmd when no valid fetch (addi x0,x0,0)
// PORTS
//   clk           in   1       clock, rising edge
//   rst           in   1       synchronous reset, active-high
//   fetch_en      in   1       core allows a new fetch
//   pc_in         in   ADDR_W  current pc from the core's PC register
//   cmd_ack       in   1       core commits cmd this cycle (PC advances at this edge)
//   cmd           out  DATA_W  fetched instruction, stable while cmd_valid
//   cmd_valid     out  1       cmd holds a good instruction for pc_in
//   fetch_err     out  1       sticky error; the unit is halted
//   err_code      out  2       01 misaligned pc, 10 bus error (rresp!=0), 11 timeout
//   imem_arvalid  out  1       read request valid
//   imem_araddr   out  ADDR_W  read address
//   imem_arready  in   1       memory accepts the request
//   imem_rvalid   in   1       read data valid
//   imem_rdata    in   DATA_W  read data
//   imem_rresp    in   2       00 OKAY, anything else is an error
//   imem_rready   out  1       unit accepts read data
// BEHAVIOUR
//   Reset (sync, rst=1 at edge), any state -> IDLE:
//     cmd=RESET_CMD, cmd_valid=0, fetch_err=0, err_code=00, arvalid=0, araddr=0,
//     rready=0, timer=0.
//     An in-flight memory transaction is abandoned. imem shares the same rst.
//   States: IDLE, AR, R, HOLD, HALT.
//   IDLE:
//     - fetch_en=0: stay.
//     - fetch_en=1, pc_in[1:0]!=0: go HALT, err_code=01.
//     - fetch_en=1, aligned: araddr<=pc_in, arvalid<=1, go AR.
//   AR:
//     - arvalid=1; araddr held constant.
//     - arready=1: arvalid<=0, rready<=1, go R.
//   R:
//     - rready=1.
//     - rvalid & rresp==00: cmd<=rdata, cmd_valid<=1, rready<=0, go HOLD.
//     - rvalid & rresp!=00: go HALT, err_code=10.
//   HOLD:
//     - cmd/cmd_valid stable.
//     - cmd_ack=1: cmd_valid<=0, go IDLE. cmd keeps the last word.
//     - The next fetch samples the updated pc_in in IDLE.
//   HALT:
//     - fetch_err=1, cmd=RESET_CMD, cmd_valid=0, arvalid=0, rready=0.
//     - Exit only by rst.
//   Timer:
//     - Cleared on entry to AR; increments each cycle in AR or R.
//     - Reaching TIMEOUT before the R->HOLD transition: go HALT, err_code=11.
//     - rvalid on the expiry cycle wins over timeout.
//     - Saturates; never wraps.
//   Latency: minimum 3 cycles from fetch_en in IDLE to cmd_valid
//     (IDLE->AR, AR->R with arready=1, R->HOLD with rvalid=1).
//     Zero-wait memory gives 4 cycles per instruction including the ack cycle.
//   Simultaneous arready & rvalid in AR: rvalid ignored; data is taken only in R.
//   cmd_ack outside HOLD is ignored. fetch_en deasserted in AR/R does not cancel the
//   transaction.
// STRUCTURE
//   Shared define header (beside the ALU-op defines): state encodings, NOP word,
//   err_code values, RRESP_OKAY.
//   Sub-module ifu_timer:
//     - Ports: clk, rst, clr, en.
//     - Outputs: expired, a saturating counter of width $clog2(TIMEOUT+1).
//   FSM and datapath registers live in ifu_fetch.
// TESTING
//   1. Zero-wait imem, pc_in=0x80000000, word 0x00500093, ack in HOLD:
//      araddr=0x80000000, cmd=0x00500093, cmd_valid 3 cycles after fetch_en, drop after ack.
//   2. arready delayed 4 cycles, rvalid delayed 2:
//      arvalid/araddr stable throughout, cmd_valid asserted exactly once, no err.
//   3. pc_in=0x80000002, fetch_en=1:
//      no arvalid ever, fetch_err=1, err_code=01, cmd=0x00000013.
//   4. rresp=2'b10 on rvalid:
//      HALT, err_code=10, cmd_valid stays 0; fetch_en/ack afterwards have no effect.
//   5. TIMEOUT=8, memory never returns rvalid:
//      fetch_err rises on cycle 8 after AR entry, err_code=11.
//      Variant: rvalid on cycle 8 completes normally.
//   6. rst asserted while in R:
//      next cycle all outputs at reset values. A late rvalid is ignored; a fresh fetch
//      succeeds.

Source files
------------

// File: rtl/ifu_fetch_pkg.sv
// Shared encodings for the instruction fetch unit: FSM states, NOP word,
// error codes and the read-response OKAY value.
package ifu_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_HOLD = 3'd3,
    ST_HALT = 3'd4
  } fetch_state_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_BUS      = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  localparam logic [1:0] RRESP_OKAY = 2'b00;

  function automatic logic is_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/ifu_timer.sv
// Saturating fetch watchdog. expired flags the last allowed cycle, so the
// FSM leaves on the same edge at which the count would reach TIMEOUT.
module ifu_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: reads the word at pc_in over a valid/ready read
// channel and holds it on cmd until the core acknowledges commit.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                TIMEOUT   = 255,
  parameter logic [DATA_W-1:0] RESET_CMD = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              cmd_ack,
  output logic [DATA_W-1:0] cmd,
  output logic              cmd_valid,
  output logic              fetch_err,
  output logic [1:0]        err_code,
  output logic              imem_arvalid,
  output logic [ADDR_W-1:0] imem_araddr,
  input  logic              imem_arready,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic [1:0]        imem_rresp,
  output logic              imem_rready
);

  fetch_state_e      state_q, state_d;
  logic [DATA_W-1:0] cmd_q, cmd_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              fetch_err_q, fetch_err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              arvalid_q, arvalid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              rready_q, rready_d;

  logic tmr_clr, tmr_en, tmr_expired;

  ifu_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cmd_valid_d = cmd_valid_q;
    fetch_err_d = fetch_err_q;
    err_code_d  = err_code_q;
    arvalid_d   = arvalid_q;
    araddr_d    = araddr_q;
    rready_d    = rready_q;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (fetch_en) begin
          if (!is_aligned(pc_in[1:0])) begin
            state_d    = ST_HALT;
            err_code_d = ERR_MISALIGN;
          end else begin
            araddr_d  = pc_in;
            arvalid_d = 1'b1;
            tmr_clr   = 1'b1;
            state_d   = ST_AR;
          end
        end
      end
      ST_AR: begin
        tmr_en = 1'b1;
        if (tmr_expired) begin
          state_d    = ST_HALT;
          err_code_d = ERR_TIMEOUT;
        end else if (imem_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_R;
        end
      end
      ST_R: begin
        tmr_en = 1'b1;
        // Data arriving on the expiry cycle still completes the fetch.
        if (imem_rvalid) begin
          if (imem_rresp == RRESP_OKAY) begin
            cmd_d       = imem_rdata;
            cmd_valid_d = 1'b1;
            rready_d    = 1'b0;
            state_d     = ST_HOLD;
          end else begin
            state_d    = ST_HALT;
            err_code_d = ERR_BUS;
          end
        end else if (tmr_expired) begin
          state_d    = ST_HALT;
          err_code_d = ERR_TIMEOUT;
        end
      end
      ST_HOLD: begin
        if (cmd_ack) begin
          cmd_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      ST_HALT: begin
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Every path into HALT parks the outputs identically.
    if (state_d == ST_HALT) begin
      fetch_err_d = 1'b1;
      cmd_d       = RESET_CMD;
      cmd_valid_d = 1'b0;
      arvalid_d   = 1'b0;
      rready_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= RESET_CMD;
      cmd_valid_q <= 1'b0;
      fetch_err_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      rready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      fetch_err_q <= fetch_err_d;
      err_code_q  <= err_code_d;
      arvalid_q   <= arvalid_d;
      araddr_q    <= araddr_d;
      rready_q    <= rready_d;
    end
  end

  assign cmd          = cmd_q;
  assign cmd_valid    = cmd_valid_q;
  assign fetch_err    = fetch_err_q;
  assign err_code     = err_code_q;
  assign imem_arvalid = arvalid_q;
  assign imem_araddr  = araddr_q;
  assign imem_rready  = rready_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a vector table of single fetches against a
// scripted memory, plus hand-written latency, timeout and reset sequences.
module tb_ifu_fetch;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic [31:0] pc_in;
  logic        cmd_ack;
  logic [31:0] cmd;
  logic        cmd_valid;
  logic        fetch_err;
  logic [1:0]  err_code;
  logic        imem_arvalid;
  logic [31:0] imem_araddr;
  logic        imem_arready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [1:0]  imem_rresp;
  logic        imem_rready;

  int checks = 0;
  int errors = 0;

  ifu_fetch #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .TIMEOUT   (8),
    .RESET_CMD (32'h0000_0013)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_en     (fetch_en),
    .pc_in        (pc_in),
    .cmd_ack      (cmd_ack),
    .cmd          (cmd),
    .cmd_valid    (cmd_valid),
    .fetch_err    (fetch_err),
    .err_code     (err_code),
    .imem_arvalid (imem_arvalid),
    .imem_araddr  (imem_araddr),
    .imem_arready (imem_arready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .imem_rresp   (imem_rresp),
    .imem_rready  (imem_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          ar_wait;
    int          r_wait;
    logic [1:0]  resp;
    logic [31:0] exp_cmd;
    logic        exp_valid;
    logic        exp_err;
    logic [1:0]  exp_code;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one rising edge and return at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    fetch_en     = 1'b0;
    pc_in        = 32'h0;
    cmd_ack      = 1'b0;
    imem_arready = 1'b0;
    imem_rvalid  = 1'b0;
    imem_rdata   = 32'h0;
    imem_rresp   = 2'b00;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd"},       cmd,                 32'h0000_0013);
    chk({tag, "_cmd_valid"}, {31'd0, cmd_valid},  32'd0);
    chk({tag, "_fetch_err"}, {31'd0, fetch_err},  32'd0);
    chk({tag, "_err_code"},  {30'd0, err_code},   32'd0);
    chk({tag, "_arvalid"},   {31'd0, imem_arvalid}, 32'd0);
    chk({tag, "_araddr"},    imem_araddr,         32'd0);
    chk({tag, "_rready"},    {31'd0, imem_rready}, 32'd0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int ar_cnt;
    int vcnt;
    logic addr_bad;
    string tag;
    tag      = $sformatf("vec%0d", idx);
    ar_cnt   = 0;
    vcnt     = 0;
    addr_bad = 1'b0;
    do_reset();
    fetch_en = 1'b1;
    pc_in    = v.pc;
    step();
    fetch_en = 1'b0;
    for (int k = 0; k <= v.ar_wait; k++) begin
      imem_arready = (k == v.ar_wait);
      if (imem_arvalid) begin
        ar_cnt++;
        if (imem_araddr !== v.pc) addr_bad = 1'b1;
      end
      if (cmd_valid) vcnt++;
      step();
    end
    imem_arready = 1'b0;
    for (int k = 0; k <= v.r_wait; k++) begin
      imem_rvalid = (k == v.r_wait);
      imem_rdata  = v.data;
      imem_rresp  = (k == v.r_wait) ? v.resp : 2'b00;
      if (imem_arvalid) ar_cnt++;
      if (cmd_valid) vcnt++;
      step();
    end
    imem_rvalid = 1'b0;
    imem_rresp  = 2'b00;
    chk({tag, "_cmd"},       cmd,                 v.exp_cmd);
    chk({tag, "_cmd_valid"}, {31'd0, cmd_valid},  {31'd0, v.exp_valid});
    chk({tag, "_fetch_err"}, {31'd0, fetch_err},  {31'd0, v.exp_err});
    chk({tag, "_err_code"},  {30'd0, err_code},   {30'd0, v.exp_code});
    chk({tag, "_rready"},    {31'd0, imem_rready}, 32'd0);
    chk({tag, "_addr_stable"}, {31'd0, addr_bad}, 32'd0);
    chk({tag, "_early_valid"}, vcnt, 0);
    if (v.exp_code == 2'b01) chk({tag, "_no_arvalid"}, ar_cnt, 0);
    if (v.exp_valid) begin
      cmd_ack = 1'b1;
      step();
      cmd_ack = 1'b0;
      chk({tag, "_ack_drop"}, {31'd0, cmd_valid}, 32'd0);
      chk({tag, "_ack_keep"}, cmd, v.exp_cmd);
    end
    if (v.exp_err) begin
      fetch_en = 1'b1;
      pc_in    = 32'h8000_0100;
      cmd_ack  = 1'b1;
      step();
      step();
      fetch_en = 1'b0;
      cmd_ack  = 1'b0;
      chk({tag, "_halt_arvalid"}, {31'd0, imem_arvalid}, 32'd0);
      chk({tag, "_halt_err"},     {31'd0, fetch_err},    32'd1);
      chk({tag, "_halt_code"},    {30'd0, err_code},     {30'd0, v.exp_code});
      chk({tag, "_halt_cmd"},     cmd,                   32'h0000_0013);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();

    //            pc            data          arw rw resp   exp_cmd       vld err code
    vecs[0] = '{32'h8000_0000, 32'h0050_0093, 0, 0, 2'b00, 32'h0050_0093, 1'b1, 1'b0, 2'b00};
    vecs[1] = '{32'h8000_0004, 32'h00A0_0113, 4, 2, 2'b00, 32'h00A0_0113, 1'b1, 1'b0, 2'b00};
    vecs[2] = '{32'h8000_0002, 32'h1111_1111, 0, 0, 2'b00, 32'h0000_0013, 1'b0, 1'b1, 2'b01};
    vecs[3] = '{32'h8000_0008, 32'hDEAD_BEEF, 1, 1, 2'b10, 32'h0000_0013, 1'b0, 1'b1, 2'b10};
    vecs[4] = '{32'h8000_000C, 32'h1234_5678, 0, 6, 2'b00, 32'h1234_5678, 1'b1, 1'b0, 2'b00};
    vecs[5] = '{32'h8000_0010, 32'h8765_4321, 0, 7, 2'b00, 32'h0000_0013, 1'b0, 1'b1, 2'b11};
    vecs[6] = '{32'h8000_0014, 32'h0BAD_F00D, 8, 0, 2'b00, 32'h0000_0013, 1'b0, 1'b1, 2'b11};

    step();
    rst = 1'b0;
    check_reset_outputs("reset");

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Minimum latency, with rvalid alongside arready in AR that must be ignored.
    do_reset();
    fetch_en = 1'b1;
    pc_in    = 32'h8000_0000;
    step();
    fetch_en = 1'b0;
    chk("lat_arvalid", {31'd0, imem_arvalid}, 32'd1);
    chk("lat_araddr",  imem_araddr, 32'h8000_0000);
    imem_arready = 1'b1;
    imem_rvalid  = 1'b1;
    imem_rdata   = 32'hFFFF_FFFF;
    step();
    imem_arready = 1'b0;
    chk("lat_valid_e1", {31'd0, cmd_valid}, 32'd0);
    chk("lat_rready",   {31'd0, imem_rready}, 32'd1);
    chk("lat_arvalid_r", {31'd0, imem_arvalid}, 32'd0);
    imem_rdata = 32'h0050_0093;
    step();
    imem_rvalid = 1'b0;
    chk("lat_valid_e2", {31'd0, cmd_valid}, 32'd1);
    chk("lat_cmd",      cmd, 32'h0050_0093);
    step();
    step();
    chk("hold_valid", {31'd0, cmd_valid}, 32'd1);
    chk("hold_cmd",   cmd, 32'h0050_0093);
    cmd_ack = 1'b1;
    step();
    cmd_ack = 1'b0;
    chk("hold_ack_drop", {31'd0, cmd_valid}, 32'd0);

    // Timeout with no response: error appears on the 8th edge after AR entry.
    do_reset();
    fetch_en = 1'b1;
    pc_in    = 32'h8000_0020;
    step();
    fetch_en     = 1'b0;
    imem_arready = 1'b1;
    step();
    imem_arready = 1'b0;
    for (int i = 2; i <= 7; i++) step();
    chk("to_err_e7", {31'd0, fetch_err}, 32'd0);
    step();
    chk("to_err_e8",  {31'd0, fetch_err}, 32'd1);
    chk("to_code_e8", {30'd0, err_code},  32'd3);
    chk("to_rready",  {31'd0, imem_rready}, 32'd0);

    // Reset while in R, late rvalid ignored, then a clean fetch.
    do_reset();
    fetch_en = 1'b1;
    pc_in    = 32'h8000_0030;
    step();
    fetch_en     = 1'b0;
    imem_arready = 1'b1;
    step();
    imem_arready = 1'b0;
    chk("rst_in_r_rready", {31'd0, imem_rready}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("rst_in_r");
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0BAD;
    step();
    imem_rvalid = 1'b0;
    chk("late_rvalid_valid", {31'd0, cmd_valid}, 32'd0);
    chk("late_rvalid_cmd",   cmd, 32'h0000_0013);
    fetch_en = 1'b1;
    pc_in    = 32'h8000_0034;
    step();
    fetch_en = 1'b0;
    chk("fresh_araddr", imem_araddr, 32'h8000_0034);
    imem_arready = 1'b1;
    step();
    imem_arready = 1'b0;
    imem_rvalid  = 1'b1;
    imem_rdata   = 32'h0010_0073;
    step();
    imem_rvalid = 1'b0;
    chk("fresh_valid", {31'd0, cmd_valid}, 32'd1);
    chk("fresh_cmd",   cmd, 32'h0010_0073);
    chk("fresh_err",   {31'd0, fetch_err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
